// File: rtl/maze_pkg.sv
// Shared MAZE network definitions: packet field widths, type encodings and the
// packet record carried from a local requester into a node pkt_in port.
package maze_pkg;

    localparam int TYPE_W = 2;
    localparam int ID_W   = 4;
    localparam int FLIT_W = 32;

    typedef enum logic [TYPE_W-1:0] {
        PKT_UNI = 2'b00,
        PKT_XMC = 2'b01,
        PKT_YMC = 2'b10,
        PKT_BC  = 2'b11
    } pkt_type_e;

    typedef struct packed {
        logic [TYPE_W-1:0] ptype;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   tgt;
        logic [FLIT_W-1:0] data;
    } pkt_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_st_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot grant to the first requester strictly after ptr_i,
// wrapping around, so ptr_i itself has lowest priority.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);

    localparam int PW = $clog2(N);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_in_arb.sv
// QoS-aware arbiter merging N_REQ local requesters into one node pkt_in port through
// a single output register, with a starvation limit on high-QoS traffic.
module pkt_in_arb
    import maze_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int STARVE_TH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_vld,
    input  logic [N_REQ-1:0]                  req_qos,
    input  logic [N_REQ-1:0][TYPE_W-1:0]      req_type,
    input  logic [N_REQ-1:0][ID_W-1:0]        req_src,
    input  logic [N_REQ-1:0][ID_W-1:0]        req_tgt,
    input  logic [N_REQ-1:0][FLIT_W-1:0]      req_data,
    output logic [N_REQ-1:0]                  req_rdy,
    output logic                              pkt_in_vld,
    output logic                              pkt_in_qos,
    output logic [TYPE_W-1:0]                 pkt_in_type,
    output logic [ID_W-1:0]                   pkt_in_src,
    output logic [ID_W-1:0]                   pkt_in_tgt,
    output logic [FLIT_W-1:0]                 pkt_in_data,
    input  logic                              pkt_in_rdy,
    output logic [$clog2(N_REQ)-1:0]          grant_id
);

    localparam int PW = $clog2(N_REQ);
    localparam int SW = $clog2(STARVE_TH + 1);

    slot_st_e         state_q, state_d;
    logic [PW-1:0]    hi_ptr_q, hi_ptr_d, lo_ptr_q, lo_ptr_d;
    logic [PW-1:0]    gid_q, win_idx;
    logic [SW-1:0]    starve_q, starve_d;
    pkt_t             pkt_q, win_pkt;
    logic             qos_q;
    logic [N_REQ-1:0] hi_req, lo_req, hi_gnt, lo_gnt, gnt;
    logic             slot_free, any_lo, force_lo, use_hi, win;

    assign hi_req    = req_vld & req_qos;
    assign lo_req    = req_vld & ~req_qos;
    assign any_lo    = |lo_req;
    assign force_lo  = any_lo && (starve_q == SW'(STARVE_TH));
    assign use_hi    = (|hi_req) && !force_lo;
    assign slot_free = (state_q == ST_EMPTY) || pkt_in_rdy;

    rr_pick #(.N(N_REQ)) u_pick_hi (.req_i(hi_req), .ptr_i(hi_ptr_q), .gnt_o(hi_gnt));
    rr_pick #(.N(N_REQ)) u_pick_lo (.req_i(lo_req), .ptr_i(lo_ptr_q), .gnt_o(lo_gnt));

    // Grant is purely a function of valid/QoS/slot state, never of packet contents.
    always_comb begin
        gnt = '0;
        if (!rst && slot_free)
            gnt = use_hi ? hi_gnt : lo_gnt;
    end

    assign req_rdy = gnt;
    assign win     = |gnt;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) win_idx = PW'(i);
    end

    assign win_pkt = '{ptype: req_type[win_idx], src: req_src[win_idx],
                       tgt: req_tgt[win_idx], data: req_data[win_idx]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (win) state_d = ST_FULL;
            ST_FULL:  if (pkt_in_rdy && !win) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        hi_ptr_d = hi_ptr_q;
        lo_ptr_d = lo_ptr_q;
        starve_d = starve_q;
        if (win) begin
            if (use_hi) hi_ptr_d = win_idx;
            else        lo_ptr_d = win_idx;
        end
        // Count only high grants that bypass a waiting low request.
        if (!any_lo || (win && !use_hi))
            starve_d = '0;
        else if (win && use_hi && (starve_q != SW'(STARVE_TH)))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            hi_ptr_q <= PW'(N_REQ - 1);
            lo_ptr_q <= PW'(N_REQ - 1);
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_ptr_q <= hi_ptr_d;
            lo_ptr_q <= lo_ptr_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q <= '0;
            qos_q <= 1'b0;
            gid_q <= '0;
        end else if (win) begin
            pkt_q <= win_pkt;
            qos_q <= req_qos[win_idx];
            gid_q <= win_idx;
        end
    end

    assign pkt_in_vld  = (state_q == ST_FULL);
    assign pkt_in_qos  = qos_q;
    assign pkt_in_type = pkt_q.ptype;
    assign pkt_in_src  = pkt_q.src;
    assign pkt_in_tgt  = pkt_q.tgt;
    assign pkt_in_data = pkt_q.data;
    assign grant_id    = gid_q;

endmodule

// File: tb/tb_pkt_in_arb.sv
// Scoreboard bench for pkt_in_arb: expected grant order is queued per scenario,
// accepted packets are queued on handshake and compared when the node takes them.
module tb_pkt_in_arb;
    import maze_pkg::*;

    localparam int N  = 4;
    localparam int PW = $clog2(N);

    logic                       clk, rst;
    logic [N-1:0]               req_vld, req_qos, req_rdy;
    logic [N-1:0][TYPE_W-1:0]   req_type;
    logic [N-1:0][ID_W-1:0]     req_src, req_tgt;
    logic [N-1:0][FLIT_W-1:0]   req_data;
    logic                       pkt_in_vld, pkt_in_qos, pkt_in_rdy;
    logic [TYPE_W-1:0]          pkt_in_type;
    logic [ID_W-1:0]            pkt_in_src, pkt_in_tgt;
    logic [FLIT_W-1:0]          pkt_in_data;
    logic [PW-1:0]              grant_id;

    int          n_chk = 0;
    int          n_bad = 0;
    int          exp_gnt[$];
    logic [63:0] sb_q[$];

    pkt_in_arb #(.N_REQ(N), .STARVE_TH(8)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_qos(req_qos), .req_type(req_type),
        .req_src(req_src), .req_tgt(req_tgt), .req_data(req_data),
        .req_rdy(req_rdy),
        .pkt_in_vld(pkt_in_vld), .pkt_in_qos(pkt_in_qos), .pkt_in_type(pkt_in_type),
        .pkt_in_src(pkt_in_src), .pkt_in_tgt(pkt_in_tgt), .pkt_in_data(pkt_in_data),
        .pkt_in_rdy(pkt_in_rdy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int id, input logic [TYPE_W-1:0] t,
                                       input logic [ID_W-1:0] s, input logic [ID_W-1:0] tg,
                                       input logic [FLIT_W-1:0] d, input logic q);
        return 64'({q, 3'(id), t, s, tg, d});
    endfunction

    task automatic setf(input int base);
        for (int i = 0; i < N; i++) begin
            req_type[i] = TYPE_W'(i);
            req_src[i]  = ID_W'(base + i);
            req_tgt[i]  = ID_W'(15 - i);
            req_data[i] = FLIT_W'(base * 256 + i * 17 + 1);
        end
    endtask

    task automatic push_n(input int id, input int n);
        for (int i = 0; i < n; i++) exp_gnt.push_back(id);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || exp_gnt.size() != 0 || pkt_in_vld) && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_sb", 64'(sb_q.size()), 64'd0);
        chk("drain_gq", 64'(exp_gnt.size()), 64'd0);
        chk("drain_vld", 64'(pkt_in_vld), 64'd0);
    endtask

    // Handshakes are sampled on the falling edge, half a cycle before they commit.
    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_in_vld && pkt_in_rdy) begin
                chk("sb_occ", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0)
                    chk("pkt", pk(int'(grant_id), pkt_in_type, pkt_in_src, pkt_in_tgt,
                                  pkt_in_data, pkt_in_qos), sb_q.pop_front());
            end
            if (req_rdy != '0) begin
                chk("gq_occ", 64'(exp_gnt.size() > 0), 64'd1);
                if (exp_gnt.size() > 0) begin
                    int e;
                    logic [N-1:0] oh;
                    e = exp_gnt.pop_front();
                    oh = '0;
                    oh[e] = 1'b1;
                    chk("gnt", 64'(req_rdy), 64'(oh));
                    sb_q.push_back(pk(e, req_type[e], req_src[e], req_tgt[e],
                                      req_data[e], req_qos[e]));
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        req_vld = '1;
        req_qos = '0;
        pkt_in_rdy = 1'b1;
        setf(1);
        #1 rst = 1'b1;

        // Reset state, with requests present but suppressed
        @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(pkt_in_vld), 64'd0);
        chk("rst_rdy", 64'(req_rdy), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_pkt", pk(0, pkt_in_type, pkt_in_src, pkt_in_tgt, pkt_in_data, pkt_in_qos), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_vld = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("idle_vld", 64'(pkt_in_vld), 64'd0);
            chk("idle_rdy", 64'(req_rdy), 64'd0);
        end

        // All four low-QoS requesters: plain round robin, no bubbles
        @(posedge clk); #1;
        setf(2);
        push_n(0, 1); push_n(1, 1); push_n(2, 1); push_n(3, 1);
        push_n(0, 1); push_n(1, 1); push_n(2, 1); push_n(3, 1);
        req_vld = 4'b1111;
        req_qos = 4'b0000;
        @(negedge clk);
        chk("vld_c0", 64'(pkt_in_vld), 64'd0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("vld_cont", 64'(pkt_in_vld), 64'd1);
        end
        @(posedge clk); #1;
        req_vld = '0;
        drain();

        // High req 0 vs low req 2: eight high grants then one forced low
        @(posedge clk); #1;
        setf(3);
        push_n(0, 8); push_n(2, 1); push_n(0, 8); push_n(2, 1);
        req_vld = 4'b0101;
        req_qos = 4'b0001;
        repeat (18) @(posedge clk);
        #1 req_vld = '0;
        drain();

        // Backpressure hold with 0xA5, then reload on the release edge
        @(posedge clk); #1;
        setf(4);
        req_data[1] = 32'hA5;
        req_vld = 4'b0010;
        req_qos = 4'b0000;
        pkt_in_rdy = 1'b0;
        push_n(1, 1);
        @(posedge clk); #1;
        req_vld = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_pkt", pk(int'(grant_id), pkt_in_type, pkt_in_src, pkt_in_tgt, pkt_in_data,
                               pkt_in_qos), pk(1, 2'd1, 4'd5, 4'd14, 32'hA5, 1'b0));
            chk("hold_vld", 64'(pkt_in_vld), 64'd1);
            chk("hold_rdy", 64'(req_rdy), 64'd0);
        end
        push_n(3, 1);
        @(posedge clk); #1;
        pkt_in_rdy = 1'b1;
        @(posedge clk); #1;
        req_vld = '0;
        drain();

        // Build up pointer/starvation history, then reset while FULL
        @(posedge clk); #1;
        setf(5);
        push_n(1, 8); push_n(0, 1); push_n(1, 2);
        req_vld = 4'b0011;
        req_qos = 4'b0010;
        repeat (11) @(posedge clk);
        #1;
        req_vld = '0;
        pkt_in_rdy = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_vld", 64'(pkt_in_vld), 64'd0);
        chk("arst_gid", 64'(grant_id), 64'd0);
        chk("arst_data", 64'(pkt_in_data), 64'd0);
        sb_q.delete();
        req_vld = 4'b1111;
        #1 chk("arst_rdy", 64'(req_rdy), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        req_vld = '0;
        pkt_in_rdy = 1'b1;

        // Fresh pointers (both N-1) and a cleared starvation count
        @(posedge clk); #1;
        setf(6);
        push_n(1, 1); push_n(3, 1); push_n(1, 1); push_n(3, 1);
        push_n(1, 1); push_n(3, 1); push_n(1, 1); push_n(3, 1);
        push_n(0, 1);
        req_vld = 4'b1111;
        req_qos = 4'b1010;
        repeat (9) @(posedge clk);
        #1 req_vld = '0;
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_in_arb.md
PKT_IN_ARB -- requirements
Module: pkt_in_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of local requesters sharing one node pkt_in port (2..8).
REQ-002 Parameter STARVE_TH, default 8: consecutive high-QoS grants tolerated while a low-QoS request waits.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_vld  input  N_REQ  per-requester packet valid.
REQ-006 req_qos  input  N_REQ  per-requester QoS (1 = high).
REQ-007 req_type  input  N_REQ*TYPE_W  per-requester packet type (00 unicast, 01 X-multicast, 10 Y-multicast, 11 broadcast).
REQ-008 req_src / req_tgt  input  N_REQ*ID_W each  per-requester source/target node ID.
REQ-009 req_data  input  N_REQ*FLIT_W  per-requester payload.
REQ-010 req_rdy  output  N_REQ  per-requester accept, one-hot or zero.
REQ-011 pkt_in_vld, pkt_in_qos, pkt_in_type, pkt_in_src, pkt_in_tgt, pkt_in_data  output  1/1/TYPE_W/ID_W/ID_W/FLIT_W  packet to node.
REQ-012 pkt_in_rdy  input  1  node backpressure.
REQ-013 grant_id  output  $clog2(N_REQ)  index of requester whose packet is held in the output register.

Function
REQ-014 Transfer on any port occurs when vld and rdy are both high at a rising edge.
REQ-015 Output stage is one register, two states: EMPTY (pkt_in_vld=0), FULL (pkt_in_vld=1).
REQ-016 Slot free this cycle = EMPTY, or FULL with pkt_in_rdy=1.
REQ-017 When slot free and any req_vld high, exactly one req_rdy is high (the winner); otherwise all req_rdy low.
REQ-018 req_rdy is combinational from req_vld, req_qos, state, pkt_in_rdy and arbiter state; it never depends on req_data/req_type/req_src/req_tgt.
REQ-019 Winner fields are registered next edge; latency request->pkt_in_vld = 1 cycle; zero-bubble back-to-back transfers when pkt_in_rdy stays high.
REQ-020 Transitions: EMPTY->FULL on winner; FULL->EMPTY on pkt_in_rdy with no winner; FULL->FULL on pkt_in_rdy with winner (reload) or on pkt_in_rdy=0 (hold).
REQ-021 While FULL and pkt_in_rdy=0, all pkt_in_* outputs and grant_id remain stable.
REQ-022 Class selection: high class if any req_vld&req_qos, else low class; forced low class when starve_cnt == STARVE_TH and a low request is valid.
REQ-023 Within a class, round-robin starting after that class's last-granted index; separate pointers hi_ptr, lo_ptr, updated only on a grant in that class.
REQ-024 starve_cnt: +1 on each high-class grant while any low request valid; cleared on low-class grant or when no low request valid; saturates at STARVE_TH.
REQ-025 Packet fields pass unmodified; no src/tgt/type checking.
REQ-026 Requester deasserting req_vld without handshake is legal; arbiter reselects same cycle.

Reset
REQ-027 On rst: state EMPTY, pkt_in_vld=0, all pkt_in_* fields 0, grant_id=0, hi_ptr=lo_ptr=N_REQ-1, starve_cnt=0.
REQ-028 req_rdy all 0 while rst high.
REQ-029 Reset mid-transfer drops the held packet; no replay after release.

Structure
REQ-030 TYPE_W, ID_W, FLIT_W and packet type encodings come from the shared MAZE package; no local redefinition.
REQ-031 Round-robin picker is sub-module rr_pick (request vector, pointer -> one-hot grant), instantiated once per class.

Verification
REQ-032 Reset release, all req_vld=0 -> pkt_in_vld=0, req_rdy=0000 indefinitely.
REQ-033 req_vld=1111 low QoS, pkt_in_rdy=1 -> grants 0,1,2,3,0 in consecutive cycles; pkt_in_vld continuously 1 from cycle 1.
REQ-034 req 0 high, req 2 low, both held valid, STARVE_TH=8 -> 8 grants to 0, then one to 2, repeat.
REQ-035 FULL with data 0xA5, pkt_in_rdy=0 for 5 cycles -> outputs stable 0xA5, req_rdy=0; pkt_in_rdy=1 -> next winner loaded same edge.
REQ-036 rst pulsed while FULL -> pkt_in_vld=0 immediately (asynchronous), pointers and starve_cnt reinitialised.
